in_service_eoi_controller: RTL and testbench

Parametrised successor to the fixed 8-level OCW2 logic of the 8259A control block. Holds the in-service register (ISR) for NUM_LEVELS interrupt levels and executes OCW2 end-of-interrupt and rotation commands:
- non-specific, specific and automatic EOI;
- rotate on EOI, set priority, and rotate in auto-EOI mode.

It sits between the priority resolver, which supplies acknowledged levels, and the control logic, which decodes OCW2 writes. It exports the ISR, the highest-priority in-service level and the current rotation point.

---
 rtl/in_service_eoi_controller.sv | 132 +++++++++++++
 tb/tb_in_service_eoi_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/in_service_eoi_controller.sv
// In-service register with OCW2 end-of-interrupt and priority rotation handling
// for NUM_LEVELS interrupt levels; successor to the fixed 8-level 8259A logic.
module in_service_eoi_controller #(
  parameter int NUM_LEVELS = 8,
  localparam int LEVEL_W = $clog2(NUM_LEVELS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_icw1,
  input  logic                  auto_eoi_config,
  input  logic                  write_ocw2,
  input  logic [2:0]            ocw2_cmd,
  input  logic [LEVEL_W-1:0]    ocw2_level,
  input  logic                  ack_valid,
  input  logic [NUM_LEVELS-1:0] ack_level,
  input  logic                  end_of_ack_sequence,
  output logic [NUM_LEVELS-1:0] in_service,
  output logic [NUM_LEVELS-1:0] highest_level_in_service,
  output logic [LEVEL_W-1:0]    priority_rotate,
  output logic                  auto_rotate_mode,
  output logic                  eoi_pulse
);

  // All inputs are single-cycle strobes with no back-pressure: a command is
  // taken on the rising edge where its strobe is high and is never stalled.

  logic [NUM_LEVELS-1:0] last_ack;

  logic [NUM_LEVELS-1:0] level_mask;
  logic [NUM_LEVELS-1:0] ocw_clear;
  logic [NUM_LEVELS-1:0] aeoi_clear;
  logic [NUM_LEVELS-1:0] isr_next;
  logic [NUM_LEVELS-1:0] last_ack_next;
  logic                  ocw_rot_en;
  logic [LEVEL_W-1:0]    ocw_rot_val;
  logic                  aeoi_fire;
  logic [LEVEL_W-1:0]    rot_next;
  logic                  mode_next;
  logic                  pulse_next;
  logic                  found;
  logic [LEVEL_W-1:0]    scan_idx;

  // Shared one-hot to level-number encoder; multi-hot inputs are illegal.
  function automatic logic [LEVEL_W-1:0] encode(input logic [NUM_LEVELS-1:0] oh);
    logic [LEVEL_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (oh[i]) n = n | LEVEL_W'(i);
    end
    return n;
  endfunction

  // Scan starts just after the lowest-priority level and wraps around.
  always_comb begin
    highest_level_in_service = '0;
    found = 1'b0;
    scan_idx = '0;
    for (int i = 1; i <= NUM_LEVELS; i++) begin
      scan_idx = priority_rotate + LEVEL_W'(i);
      if (!found && in_service[scan_idx]) begin
        highest_level_in_service[scan_idx] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    level_mask  = NUM_LEVELS'(1) << ocw2_level;
    ocw_clear   = '0;
    ocw_rot_en  = 1'b0;
    ocw_rot_val = ocw2_level;
    mode_next   = auto_rotate_mode;
    if (write_ocw2) begin
      case (ocw2_cmd)
        3'b001: ocw_clear = highest_level_in_service;
        3'b011: ocw_clear = level_mask;
        3'b101: begin
          ocw_clear   = highest_level_in_service;
          ocw_rot_en  = |highest_level_in_service;
          ocw_rot_val = encode(highest_level_in_service);
        end
        3'b111: begin
          ocw_clear  = level_mask;
          ocw_rot_en = 1'b1;
        end
        3'b110: ocw_rot_en = 1'b1;
        3'b100: mode_next = 1'b1;
        3'b000: mode_next = 1'b0;
        default: ;
      endcase
    end

    aeoi_fire  = end_of_ack_sequence && auto_eoi_config;
    aeoi_clear = aeoi_fire ? last_ack : '0;

    // Clears use the pre-edge ISR; a same-cycle acknowledge wins over a clear.
    isr_next = (in_service & ~(ocw_clear | aeoi_clear)) | (ack_valid ? ack_level : '0);

    if (ocw_rot_en)
      rot_next = ocw_rot_val;
    else if (aeoi_fire && auto_rotate_mode && |last_ack)
      rot_next = encode(last_ack);
    else
      rot_next = priority_rotate;

    pulse_next    = |(in_service & ~isr_next);
    last_ack_next = ack_valid ? ack_level : last_ack;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_service       <= '0;
      priority_rotate  <= LEVEL_W'(NUM_LEVELS - 1);
      auto_rotate_mode <= 1'b0;
      eoi_pulse        <= 1'b0;
      last_ack         <= '0;
    end else if (write_icw1) begin
      in_service       <= '0;
      priority_rotate  <= LEVEL_W'(NUM_LEVELS - 1);
      auto_rotate_mode <= 1'b0;
      eoi_pulse        <= 1'b0;
      last_ack         <= '0;
    end else begin
      in_service       <= isr_next;
      priority_rotate  <= rot_next;
      auto_rotate_mode <= mode_next;
      eoi_pulse        <= pulse_next;
      last_ack         <= last_ack_next;
    end
  end

endmodule

// File: tb/tb_in_service_eoi_controller.sv
// Bench for in_service_eoi_controller: directed scenarios on 8- and 16-level
// instances, then random traffic against a level-based reference model.
module tb_in_service_eoi_controller;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // 8-level instance
  logic       write_icw1 = 0, auto_eoi_config = 0, write_ocw2 = 0;
  logic [2:0] ocw2_cmd = 0, ocw2_level = 0;
  logic       ack_valid = 0, end_of_ack_sequence = 0;
  logic [7:0] ack_level = 0;
  logic [7:0] in_service, highest_level_in_service;
  logic [2:0] priority_rotate;
  logic       auto_rotate_mode, eoi_pulse;

  // 16-level instance
  logic        b_write_ocw2 = 0, b_ack_valid = 0;
  logic [2:0]  b_ocw2_cmd = 0;
  logic [3:0]  b_ocw2_level = 0;
  logic [15:0] b_ack_level = 0;
  logic [15:0] b_in_service, b_highest;
  logic [3:0]  b_priority_rotate;
  logic        b_auto_rotate_mode, b_eoi_pulse;
  logic        b_zero = 1'b0;

  in_service_eoi_controller #(.NUM_LEVELS(8)) dut (
    .clock(clock), .reset(reset), .write_icw1(write_icw1),
    .auto_eoi_config(auto_eoi_config), .write_ocw2(write_ocw2),
    .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level), .ack_valid(ack_valid),
    .ack_level(ack_level), .end_of_ack_sequence(end_of_ack_sequence),
    .in_service(in_service), .highest_level_in_service(highest_level_in_service),
    .priority_rotate(priority_rotate), .auto_rotate_mode(auto_rotate_mode),
    .eoi_pulse(eoi_pulse)
  );

  in_service_eoi_controller #(.NUM_LEVELS(16)) dut16 (
    .clock(clock), .reset(reset), .write_icw1(b_zero),
    .auto_eoi_config(b_zero), .write_ocw2(b_write_ocw2),
    .ocw2_cmd(b_ocw2_cmd), .ocw2_level(b_ocw2_level), .ack_valid(b_ack_valid),
    .ack_level(b_ack_level), .end_of_ack_sequence(b_zero),
    .in_service(b_in_service), .highest_level_in_service(b_highest),
    .priority_rotate(b_priority_rotate), .auto_rotate_mode(b_auto_rotate_mode),
    .eoi_pulse(b_eoi_pulse)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    write_icw1 = 0; write_ocw2 = 0; ack_valid = 0; end_of_ack_sequence = 0;
    b_write_ocw2 = 0; b_ack_valid = 0;
  endtask

  task automatic ack(input int lvl);
    ack_valid = 1; ack_level = 8'(1 << lvl);
    tick();
  endtask

  task automatic ocw2(input logic [2:0] cmd, input int lvl);
    write_ocw2 = 1; ocw2_cmd = cmd; ocw2_level = 3'(lvl);
    tick();
  endtask

  // ---------------- reference model (levels as integers) ----------------
  bit m_isr[8];
  int m_rot;
  bit m_mode;
  int m_last;   // -1 when nothing has been acknowledged
  bit m_pulse;

  task automatic model_reset();
    foreach (m_isr[l]) m_isr[l] = 0;
    m_rot = 7; m_mode = 0; m_last = -1; m_pulse = 0;
  endtask

  function automatic int model_highest();
    for (int p = 1; p <= 8; p++) begin
      int l;
      l = (m_rot + p) % 8;
      if (m_isr[l]) return l;
    end
    return -1;
  endfunction

  task automatic model_step(input bit icw1, input bit cfg, input bit w2, input int cmd,
                            input int lvl, input bit ackv, input int ackl, input bit eoas);
    bit clr[8];
    bit nisr[8];
    int h, new_rot;
    bit ocw_rot, old_mode;
    if (icw1) begin
      model_reset();
      return;
    end
    foreach (clr[l]) clr[l] = 0;
    h = model_highest();
    new_rot = m_rot; ocw_rot = 0; old_mode = m_mode;
    if (w2) begin
      case (cmd)
        1: if (h >= 0) clr[h] = 1;
        3: clr[lvl] = 1;
        5: if (h >= 0) begin clr[h] = 1; new_rot = h; ocw_rot = 1; end
        7: begin clr[lvl] = 1; new_rot = lvl; ocw_rot = 1; end
        6: begin new_rot = lvl; ocw_rot = 1; end
        4: m_mode = 1;
        0: m_mode = 0;
        default: ;
      endcase
    end
    if (eoas && cfg && m_last >= 0) begin
      clr[m_last] = 1;
      if (old_mode && !ocw_rot) new_rot = m_last;
    end
    m_pulse = 0;
    for (int l = 0; l < 8; l++) begin
      nisr[l] = (ackv && l == ackl) ? 1'b1 : (m_isr[l] && !clr[l]);
      if (m_isr[l] && !nisr[l]) m_pulse = 1;
    end
    m_isr = nisr;
    m_rot = new_rot;
    if (ackv) m_last = ackl;
  endtask

  function automatic logic [31:0] model_pack();
    logic [31:0] e;
    int h;
    e = '0;
    for (int l = 0; l < 8; l++) e[l] = m_isr[l];
    h = model_highest();
    if (h >= 0) e[8 + h] = 1'b1;
    e[18:16] = 3'(m_rot);
    e[19] = m_mode;
    e[20] = m_pulse;
    return e;
  endfunction

  // ---------------- directed steps then random traffic ----------------
  initial begin
    @(posedge clock); @(posedge clock); #1;
    reset = 0;
    check("reset_isr", in_service, 8'h00);
    check("reset_rot", priority_rotate, 3'd7);
    check("reset_mode", auto_rotate_mode, 1'b0);
    check("reset_pulse", eoi_pulse, 1'b0);
    check("reset_highest", highest_level_in_service, 8'h00);

    ack(3); ack(5);
    check("ack35_isr", in_service, 8'h28);
    check("ack35_highest", highest_level_in_service, 8'h08);
    ocw2(3'b001, 0);
    check("nseoi_isr", in_service, 8'h20);
    check("nseoi_pulse", eoi_pulse, 1'b1);
    tick();
    check("nseoi_pulse_drop", eoi_pulse, 1'b0);

    ocw2(3'b011, 5);
    check("seoi_isr", in_service, 8'h00);
    check("seoi_pulse", eoi_pulse, 1'b1);
    ocw2(3'b011, 5);
    check("seoi_noop_isr", in_service, 8'h00);
    check("seoi_noop_pulse", eoi_pulse, 1'b0);

    ack(1); ack(4);
    check("isr12", in_service, 8'h12);
    ocw2(3'b101, 0);
    check("rnseoi_isr", in_service, 8'h10);
    check("rnseoi_rot", priority_rotate, 3'd1);
    check("rnseoi_highest", highest_level_in_service, 8'h10);
    ocw2(3'b110, 3);
    check("setpri_rot", priority_rotate, 3'd3);
    check("setpri_isr", in_service, 8'h10);

    auto_eoi_config = 1;
    ocw2(3'b100, 0);
    check("arm_mode", auto_rotate_mode, 1'b1);
    ack(6);
    check("aeoi_set", in_service, 8'h50);
    end_of_ack_sequence = 1; tick();
    check("aeoi_isr", in_service, 8'h10);
    check("aeoi_rot", priority_rotate, 3'd6);
    check("aeoi_pulse", eoi_pulse, 1'b1);

    auto_eoi_config = 0;
    ack(2);
    ack_valid = 1; ack_level = 8'h04; write_ocw2 = 1; ocw2_cmd = 3'b011; ocw2_level = 3'd2;
    tick();
    check("set_wins_isr", in_service, 8'h14);

    write_icw1 = 1; tick();
    check("icw1_isr", in_service, 8'h00);
    check("icw1_rot", priority_rotate, 3'd7);
    check("icw1_mode", auto_rotate_mode, 1'b0);
    check("icw1_highest", highest_level_in_service, 8'h00);

    ocw2(3'b101, 0);
    check("rnseoi_empty_rot", priority_rotate, 3'd7);
    check("rnseoi_empty_pulse", eoi_pulse, 1'b0);
    ocw2(3'b111, 4);
    check("rseoi_clear_rot", priority_rotate, 3'd4);
    check("rseoi_clear_pulse", eoi_pulse, 1'b0);

    ack(0);
    end_of_ack_sequence = 1; tick();
    check("no_aeoi_cfg0", in_service, 8'h01);

    ack(1);
    auto_eoi_config = 1;
    #2 reset = 1;
    #1 check("async_reset_isr", in_service, 8'h00);
    check("async_reset_rot", priority_rotate, 3'd7);
    reset = 0;
    end_of_ack_sequence = 1; tick();
    check("post_reset_eoas_isr", in_service, 8'h00);
    check("post_reset_eoas_pulse", eoi_pulse, 1'b0);
    auto_eoi_config = 0;

    // 16-level instance
    b_ack_valid = 1; b_ack_level = 16'h0001; tick();
    b_ack_valid = 1; b_ack_level = 16'h8000; tick();
    check("n16_isr", b_in_service, 16'h8001);
    b_write_ocw2 = 1; b_ocw2_cmd = 3'b111; b_ocw2_level = 4'd15; tick();
    check("n16_isr_after", b_in_service, 16'h0001);
    check("n16_rot", b_priority_rotate, 4'd15);
    check("n16_highest", b_highest, 16'h0001);
    check("n16_pulse", b_eoi_pulse, 1'b1);

    // random traffic against the model
    write_icw1 = 1; tick();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      bit icw1, w2, ackv, eoas;
      int cmd, lvl, ackl;
      logic [31:0] expv;
      icw1 = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) auto_eoi_config = ~auto_eoi_config;
      w2   = ($urandom_range(0, 2) == 0);
      cmd  = $urandom_range(0, 7);
      lvl  = $urandom_range(0, 7);
      ackv = ($urandom_range(0, 2) == 0);
      ackl = $urandom_range(0, 7);
      eoas = ($urandom_range(0, 3) == 0);
      model_step(icw1, auto_eoi_config, w2, cmd, lvl, ackv, ackl, eoas);
      exp_q.push_back(model_pack());
      write_icw1 = icw1; write_ocw2 = w2; ocw2_cmd = 3'(cmd); ocw2_level = 3'(lvl);
      ack_valid = ackv; ack_level = 8'(1 << ackl); end_of_ack_sequence = eoas;
      tick();
      expv = exp_q.pop_front();
      check("random", {11'b0, eoi_pulse, auto_rotate_mode, priority_rotate,
                       highest_level_in_service, in_service}, expv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
